disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Sequencer for the four-digit 7-segment display. Generates the active-low digit select `sel` that steers the time-digit multiplexer, owns the display-mode flags `show_in` (hour:min vs min:sec) and `alarm_d` (clock vs alarm time), and drives the colon decimal point. Sits between the debounced push-button pulses and the digit mux and segment decoder.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot. Must be ≥ `BLANK_CYC`+2.
- `BLANK_CYC`, 500: cycles at the start of each slot during which all digits are off (anti-ghosting). Must be ≥ 1.
- `ALM_HOLD`, 2000: full scan frames the alarm view stays up without a button press before it reverts to clock view. 0 disables the timeout. Must fit in 16 bits.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mode_btn` in 1: single-cycle pulse; toggles `show_in`.
- `alarm_btn` in 1: single-cycle pulse; toggles `alarm_d`.
- `sec_tick` in 1: single-cycle pulse once per second, from the time counter.
- `sel` out 4: active-low digit enable. 1110 = digit 0 (rightmost), 1101, 1011, 0111 = digit 3. 1111 = all off.
- `show_in` out 1: 0 = hour:min, 1 = min:sec.
- `alarm_d` out 1: 0 = clock time, 1 = alarm time.
- `dp` out 1: colon decimal point, active high.

## Operation
- **Prescaler** `pcnt` (width clog2(`SCAN_DIV`)) counts 0..`SCAN_DIV`-1 and wraps. `tick` = (`pcnt`==`SCAN_DIV`-1).
- **Digit index** `idx[1:0]` advances on `tick`: 0→1→2→3→0. A frame ends on a `tick` with `idx`==3.
- **sel** (registered):
  - 1111 while `pcnt` < `BLANK_CYC`.
  - Otherwise the decode of `idx`: 0→1110, 1→1101, 2→1011, 3→0111.
  - Exactly one bit is ever low.
- **Mode FSM.** The four states {CLK_HM, CLK_MS, ALM_HM, ALM_MS} are encoded directly as {`alarm_d`, `show_in`}.
  - `mode_btn` flips `show_in`.
  - `alarm_btn` flips `alarm_d`.
  - Both in the same cycle: both flip, e.g. CLK_HM→ALM_MS.
  - Changes take effect immediately, not deferred to a frame boundary.
- **Alarm timeout.** 16-bit `hold_cnt`.
  - Cleared to 0 on any button pulse and whenever `alarm_d`==0.
  - While `alarm_d`==1, increments on each frame end.
  - Timeout fires on a frame end when the incremented value equals `ALM_HOLD` (`ALM_HOLD`≠0). It clears `alarm_d` and `hold_cnt`; `show_in` is unchanged.
  - A button pulse in the same cycle as the timeout suppresses the timeout; the button action applies instead.
- **Colon.**
  - `colon_on` toggles on each `sec_tick` and is held at 1 while `alarm_d`==1.
  - `dp` = `colon_on` & (`idx`==2) & (`pcnt` ≥ `BLANK_CYC`), registered and aligned with `sel`.

## Timing
- **Reset values:** `pcnt`=0, `idx`=0, `sel`=1111, `show_in`=0, `alarm_d`=0, `dp`=0, `colon_on`=0, `hold_cnt`=0. `rst_n` low mid-frame forces these immediately (asynchronously).
- **Output latency:** all outputs are registered. `sel`/`dp` reflect the `pcnt`/`idx` values of the previous cycle, one cycle of latency.
- **Button response:** a pulse in cycle N produces the new `show_in`/`alarm_d` in cycle N+1.
- **First enable after reset release:** `sel` goes to 1110 `BLANK_CYC`+1 cycles after the first active clock edge.
- **Slot shape:** each slot is `SCAN_DIV` cycles, of which `BLANK_CYC` cycles read 1111. One frame is 4×`SCAN_DIV` cycles.
- **Timeout instant:** `alarm_d` falls in the cycle after the `ALM_HOLD`-th frame end following the last button pulse (or the alarm entry).
- **Boundary cases:**
  - `sec_tick` coinciding with `tick` or a button pulse: all actions apply independently.
  - `sec_tick` while `alarm_d`==1: `colon_on` stays 1. On return to clock view, `colon_on` resumes toggling from 1.
- **Width rules:** `hold_cnt` saturates at 16'hFFFF when `ALM_HOLD`=0; it never wraps.

## Test plan
All scenarios use `SCAN_DIV`=8, `BLANK_CYC`=2, `ALM_HOLD`=3.
- **Reset and scan order:** release reset, run 64 cycles.
  - `sel` = 1111 at reset.
  - Thereafter, per 8-cycle slot: 1111 ×2, then 1110 ×6, then 1111 ×2, then 1101 ×6, and so on through 1011 and 0111, repeating.
  - Never two bits low at once.
- **Mode toggles:**
  - `mode_btn` at cycle 20 → `show_in`=1 at cycle 21.
  - `alarm_btn` and `mode_btn` together at cycle 30 → {`alarm_d`,`show_in`} goes 01→10 at cycle 31.
- **Alarm timeout:** enter alarm view, no further buttons → `alarm_d` returns to 0 one cycle after the 3rd frame end (≤96 cycles after entry); `show_in` is preserved.
- **Timeout restart:** enter alarm view, pulse `mode_btn` on the exact cycle of the 3rd frame end → `alarm_d` stays 1, `show_in` flips; timeout then occurs 3 frames later.
- **Colon:**
  - `sec_tick` every 40 cycles → `dp` high only during the non-blank cycles of the `sel`=1011 slot, on alternate seconds.
  - In alarm view, `dp` is high in every 1011 slot.
- **Reset mid-operation:** assert `rst_n`=0 in state ALM_MS with `sel`=0111 → all outputs reach their reset values in the same cycle, asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// Button/tick inputs and display-side outputs of the 7-segment scan sequencer.
// The master side (button conditioning / time counter) drives the pulses;
// the slave side (the sequencer) drives digit select, mode flags and colon.
interface disp_scan_ctrl_if;
  logic       mode_btn;
  logic       alarm_btn;
  logic       sec_tick;
  logic [3:0] sel;
  logic       show_in;
  logic       alarm_d;
  logic       dp;

  modport master (
    output mode_btn,
    output alarm_btn,
    output sec_tick,
    input  sel,
    input  show_in,
    input  alarm_d,
    input  dp
  );

  modport slave (
    input  mode_btn,
    input  alarm_btn,
    input  sec_tick,
    output sel,
    output show_in,
    output alarm_d,
    output dp
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Four-digit 7-segment scan sequencer: active-low digit select with a blanking
// gap at the start of every slot, the clock/alarm and hour:min/min:sec view
// flags, an alarm-view inactivity timeout and the blinking colon.
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int ALM_HOLD  = 2000
) (
  input  logic            clk,
  input  logic            rst_n,
  disp_scan_ctrl_if.slave bus
);

  localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
  localparam logic [15:0]   HOLD_LIM  = 16'(ALM_HOLD);
  localparam logic [15:0]   HOLD_SAT  = 16'hFFFF;
  localparam bit            HOLD_EN   = (ALM_HOLD != 0);

  // View state; the encoding is literally {alarm_d, show_in}
  typedef enum logic [1:0] {
    CLK_HM = 2'b00,
    CLK_MS = 2'b01,
    ALM_HM = 2'b10,
    ALM_MS = 2'b11
  } mode_e;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic          dp_q, dp_d;
  mode_e         state_q, state_d;
  logic          colon_q, colon_d;
  logic [15:0]   hold_q, hold_d;

  logic          tick;
  logic          frame_end;
  logic          in_blank;
  logic          btn_any;
  logic          alarm_now;
  logic          alarm_nxt;
  logic          timeout;
  logic [15:0]   hold_inc;

  // Slot prescaler and digit index: a slot ends on tick, a frame on the tick of digit 3
  always_comb begin
    tick      = (pcnt_q == PCNT_MAX);
    frame_end = tick && (idx_q == 2'd3);
    in_blank  = (pcnt_q < BLANK_END);
    pcnt_d    = tick ? '0 : pcnt_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
  end

  // Digit select decode; all digits dark during the blanking gap to stop ghosting
  always_comb begin
    sel_d = 4'b1111;
    if (!in_blank) begin
      unique case (idx_q)
        2'd0: sel_d = 4'b1110;
        2'd1: sel_d = 4'b1101;
        2'd2: sel_d = 4'b1011;
        2'd3: sel_d = 4'b0111;
        default: sel_d = 4'b1111;
      endcase
    end
  end

  // Colon point lights only on digit 2, outside the blanking gap, so it tracks sel exactly
  always_comb begin
    dp_d = colon_q && (idx_q == 2'd2) && !in_blank;
  end

  // Scan pipeline registers: sel and dp lag pcnt/idx by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q  <= 2'd0;
      sel_q  <= 4'b1111;
      dp_q   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      dp_q   <= dp_d;
    end
  end

  // Alarm inactivity counter; a button press in the timeout cycle wins over the timeout
  always_comb begin
    btn_any   = bus.mode_btn || bus.alarm_btn;
    alarm_now = (state_q == ALM_HM) || (state_q == ALM_MS);
    hold_inc  = hold_q + 16'd1;
    timeout   = HOLD_EN && alarm_now && frame_end && !btn_any &&
                (hold_q != HOLD_SAT) && (hold_inc == HOLD_LIM);
    hold_d    = hold_q;
    if (btn_any || !alarm_now || timeout) begin
      hold_d = '0;
    end else if (frame_end && (hold_q != HOLD_SAT)) begin
      hold_d = hold_inc;
    end
  end

  // Next view: each button flips its own flag at once; timeout drops back to clock view
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLK_HM: begin
        if (bus.alarm_btn && bus.mode_btn) state_d = ALM_MS;
        else if (bus.alarm_btn)            state_d = ALM_HM;
        else if (bus.mode_btn)             state_d = CLK_MS;
      end
      CLK_MS: begin
        if (bus.alarm_btn && bus.mode_btn) state_d = ALM_HM;
        else if (bus.alarm_btn)            state_d = ALM_MS;
        else if (bus.mode_btn)             state_d = CLK_HM;
      end
      ALM_HM: begin
        if (bus.alarm_btn && bus.mode_btn) state_d = CLK_MS;
        else if (bus.alarm_btn)            state_d = CLK_HM;
        else if (bus.mode_btn)             state_d = ALM_MS;
        else if (timeout)                  state_d = CLK_HM;
      end
      ALM_MS: begin
        if (bus.alarm_btn && bus.mode_btn) state_d = CLK_HM;
        else if (bus.alarm_btn)            state_d = CLK_MS;
        else if (bus.mode_btn)             state_d = ALM_HM;
        else if (timeout)                  state_d = CLK_MS;
      end
      default: state_d = CLK_HM;
    endcase
  end

  // Colon blinks per second in clock view and is pinned on whenever alarm view is (becoming) active
  always_comb begin
    alarm_nxt = (state_d == ALM_HM) || (state_d == ALM_MS);
    colon_d   = colon_q;
    if (alarm_nxt) begin
      colon_d = 1'b1;
    end else if (bus.sec_tick) begin
      colon_d = ~colon_q;
    end
  end

  // View state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLK_HM;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout counter and colon phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      colon_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      colon_q <= colon_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.show_in = (state_q == CLK_MS) || (state_q == ALM_MS);
  assign bus.alarm_d = (state_q == ALM_HM) || (state_q == ALM_MS);
  assign bus.dp      = dp_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a small scan geometry so whole
// frames and alarm timeouts fit in a few hundred cycles.
module tb_disp_scan_ctrl;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int AH = 3;
  localparam int FRAME = 4 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  disp_scan_ctrl_if bus();

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ALM_HOLD(AH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: view flags, colon phase, frames since last activity, and
  // the number of clock edges since reset release (slot position is derived
  // arithmetically from that count)
  int       m_cyc;
  logic     m_show, m_alarm, m_colon;
  int       m_hold;
  logic [3:0] m_sel;
  logic     m_dp;

  task automatic model_reset();
    m_cyc = 0; m_show = 0; m_alarm = 0; m_colon = 0; m_hold = 0;
    m_sel = 4'hF; m_dp = 0;
  endtask

  // One clock edge: the model consumes the inputs set on the previous falling edge,
  // then pulses are cleared on the next falling edge
  task automatic cycle();
    int p, i;
    bit fe, btn;
    @(posedge clk);
    p = m_cyc % SD;
    i = (m_cyc / SD) % 4;
    m_sel = (p < BC) ? 4'hF : ~(4'b0001 << i);
    m_dp  = m_colon && (i == 2) && (p >= BC);
    fe  = (m_cyc % FRAME) == FRAME - 1;
    btn = bus.mode_btn || bus.alarm_btn;
    if (btn) begin
      m_show  = m_show ^ bus.mode_btn;
      m_alarm = m_alarm ^ bus.alarm_btn;
      m_hold  = 0;
    end else if (m_alarm && fe) begin
      m_hold++;
      if (m_hold == AH) begin
        m_alarm = 0;
        m_hold  = 0;
      end
    end else if (!m_alarm) begin
      m_hold = 0;
    end
    if (m_alarm) m_colon = 1;
    else if (bus.sec_tick) m_colon = ~m_colon;
    m_cyc++;
    @(negedge clk);
    bus.mode_btn = 0; bus.alarm_btn = 0; bus.sec_tick = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    bus.mode_btn = 0; bus.alarm_btn = 0; bus.sec_tick = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // Edge count (pre-edge value) of the ALM_HOLD-th frame end after an entry edge at c0
  function automatic int third_frame_end(int c0);
    int f1;
    f1 = c0 - (c0 % FRAME) + FRAME - 1;
    if (f1 <= c0) f1 += FRAME;
    return f1 + (AH - 1) * FRAME;
  endfunction

  task automatic test_reset();
    int first;
    do_reset();
    n_cmp++;
    if ({bus.sel, bus.show_in, bus.alarm_d, bus.dp} !== 7'b1111_000) begin
      n_bad++;
      $display("[TB] FAIL reset_state: got %b, want 1111000", {bus.sel, bus.show_in, bus.alarm_d, bus.dp});
    end
    first = -1;
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (first < 0 && bus.sel === 4'b1110) first = m_cyc;
      n_cmp++;
      if ({bus.sel, bus.show_in, bus.alarm_d, bus.dp} !== {m_sel, m_show, m_alarm, m_dp}) begin
        n_bad++;
        $display("[TB] FAIL scan_order c%0d: got sel=%b dp=%b, want sel=%b dp=%b", m_cyc, bus.sel, bus.dp, m_sel, m_dp);
      end
      n_cmp++;
      if (!(bus.sel === 4'hF || (!$isunknown(bus.sel) && $countones(~bus.sel) == 1))) begin
        n_bad++;
        $display("[TB] FAIL sel_onehot c%0d: got %b, want at most one low bit", m_cyc, bus.sel);
      end
    end
    n_cmp++;
    if (first != BC + 1) begin
      n_bad++;
      $display("[TB] FAIL first_enable: got edge %0d, want edge %0d", first, BC + 1);
    end
  endtask

  task automatic test_mode_toggles();
    do_reset();
    repeat (20) cycle();
    bus.mode_btn = 1;
    cycle();
    n_cmp++;
    if ({bus.alarm_d, bus.show_in} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL mode_btn: got %b, want 01", {bus.alarm_d, bus.show_in});
    end
    repeat (9) cycle();
    bus.mode_btn = 1; bus.alarm_btn = 1;
    cycle();
    n_cmp++;
    if ({bus.alarm_d, bus.show_in} !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL both_btn: got %b, want 10", {bus.alarm_d, bus.show_in});
    end
    // Random buttons and second ticks against the model
    for (int k = 0; k < 400; k++) begin
      bus.mode_btn  = ($urandom_range(0, 15) == 0);
      bus.alarm_btn = ($urandom_range(0, 15) == 0);
      bus.sec_tick  = ($urandom_range(0, 9) == 0);
      cycle();
      n_cmp++;
      if ({bus.sel, bus.show_in, bus.alarm_d, bus.dp} !== {m_sel, m_show, m_alarm, m_dp}) begin
        n_bad++;
        $display("[TB] FAIL random c%0d: got %b/%b%b/%b, want %b/%b%b/%b", m_cyc, bus.sel, bus.alarm_d, bus.show_in, bus.dp, m_sel, m_alarm, m_show, m_dp);
      end
    end
  endtask

  task automatic test_alarm_timeout();
    int c0, f3, fall;
    do_reset();
    repeat (5) cycle();
    bus.mode_btn = 1;
    cycle();
    c0 = m_cyc;
    f3 = third_frame_end(c0);
    bus.alarm_btn = 1;
    cycle();
    fall = -1;
    for (int k = 0; k < 200 && fall < 0; k++) begin
      cycle();
      n_cmp++;
      if ({bus.sel, bus.show_in, bus.alarm_d, bus.dp} !== {m_sel, m_show, m_alarm, m_dp}) begin
        n_bad++;
        $display("[TB] FAIL timeout_track c%0d: got %b/%b%b/%b, want %b/%b%b/%b", m_cyc, bus.sel, bus.alarm_d, bus.show_in, bus.dp, m_sel, m_alarm, m_show, m_dp);
      end
      if (bus.alarm_d === 1'b0) fall = m_cyc - 1;
    end
    n_cmp++;
    if (fall != f3 || (f3 - c0) > 3 * FRAME) begin
      n_bad++;
      $display("[TB] FAIL timeout_instant: got edge %0d, want edge %0d", fall, f3);
    end
    n_cmp++;
    if (bus.show_in !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL timeout_show: got %b, want 1", bus.show_in);
    end
  endtask

  task automatic test_timeout_restart();
    int c0, f3;
    do_reset();
    repeat (3) cycle();
    c0 = m_cyc;
    f3 = third_frame_end(c0);
    bus.alarm_btn = 1;
    cycle();
    while (m_cyc < f3) begin
      cycle();
      n_cmp++;
      if ({bus.sel, bus.show_in, bus.alarm_d, bus.dp} !== {m_sel, m_show, m_alarm, m_dp}) begin
        n_bad++;
        $display("[TB] FAIL restart_track c%0d: got %b%b, want %b%b", m_cyc, bus.alarm_d, bus.show_in, m_alarm, m_show);
      end
    end
    bus.mode_btn = 1;
    cycle();
    n_cmp++;
    if ({bus.alarm_d, bus.show_in} !== 2'b11) begin
      n_bad++;
      $display("[TB] FAIL restart_press: got %b, want 11", {bus.alarm_d, bus.show_in});
    end
    while (m_cyc < f3 + AH * FRAME) cycle();
    n_cmp++;
    if (bus.alarm_d !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL restart_early: got alarm_d=%b, want 1", bus.alarm_d);
    end
    cycle();
    n_cmp++;
    if ({bus.alarm_d, bus.show_in} !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL restart_timeout: got %b, want 01", {bus.alarm_d, bus.show_in});
    end
  endtask

  task automatic test_colon();
    int dut_hi, mdl_hi, alm_slots;
    do_reset();
    dut_hi = 0; mdl_hi = 0;
    for (int k = 0; k < 320; k++) begin
      bus.sec_tick = (m_cyc % 40 == 39);
      cycle();
      if (bus.dp === 1'b1) dut_hi++;
      if (m_dp) mdl_hi++;
      n_cmp++;
      if ({bus.sel, bus.dp} !== {m_sel, m_dp}) begin
        n_bad++;
        $display("[TB] FAIL colon_clock c%0d: got sel=%b dp=%b, want sel=%b dp=%b", m_cyc, bus.sel, bus.dp, m_sel, m_dp);
      end
    end
    n_cmp++;
    if (dut_hi != mdl_hi || mdl_hi == 0) begin
      n_bad++;
      $display("[TB] FAIL colon_count: got %0d, want %0d", dut_hi, mdl_hi);
    end
    bus.alarm_btn = 1;
    cycle();
    alm_slots = 0;
    for (int k = 0; k < 64; k++) begin
      bus.sec_tick = (m_cyc % 40 == 39);
      cycle();
      if (m_alarm && m_sel == 4'b1011) begin
        alm_slots++;
        n_cmp++;
        if (bus.dp !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL colon_alarm c%0d: got dp=%b, want 1", m_cyc, bus.dp);
        end
      end
    end
    n_cmp++;
    if (alm_slots == 0) begin
      n_bad++;
      $display("[TB] FAIL colon_alarm_slots: got %0d lit cycles, want more than 0", alm_slots);
    end
  endtask

  task automatic test_reset_midop();
    int k;
    do_reset();
    bus.mode_btn = 1; bus.alarm_btn = 1;
    cycle();
    k = 0;
    while (m_sel != 4'b0111 && k < 64) begin
      cycle();
      k++;
    end
    n_cmp++;
    if ({bus.sel, bus.alarm_d, bus.show_in} !== 6'b0111_11) begin
      n_bad++;
      $display("[TB] FAIL midop_setup: got %b, want 011111", {bus.sel, bus.alarm_d, bus.show_in});
    end
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if ({bus.sel, bus.show_in, bus.alarm_d, bus.dp} !== 7'b1111_000) begin
      n_bad++;
      $display("[TB] FAIL midop_reset: got %b, want 1111000", {bus.sel, bus.show_in, bus.alarm_d, bus.dp});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  // Hard stop in case something never returns
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    bus.mode_btn = 0; bus.alarm_btn = 0; bus.sec_tick = 0;
    model_reset();
    test_reset();
    test_mode_toggles();
    test_alarm_timeout();
    test_timeout_restart();
    test_colon();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
